dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 8, data memory address width.
REQ-002 Parameter DW, default 8, data memory word width.
REQ-003 Parameter STARVE_LIMIT, default 4, host wait cycles before forced grant; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 cpu_req  input  1  MEM-stage access request (memRead or memWrite).
REQ-007 cpu_we  input  1  1 = write, 0 = read.
REQ-008 cpu_addr  input  AW  page-adjusted address.
REQ-009 cpu_wdata  input  DW  store data.
REQ-010 cpu_stall  output  1  CPU access not serviced this cycle; pipeline holds.
REQ-011 cpu_rdata  output  DW  read data for the CPU.
REQ-012 host_req  input  1  host loader/dump request; held until host_gnt.
REQ-013 host_we, host_addr, host_wdata  input  1/AW/DW  host access fields.
REQ-014 host_gnt  output  1  host access issued this cycle.
REQ-015 host_rvalid  output  1  host_rdata valid.
REQ-016 host_rdata  output  DW  read data for the host.
REQ-017 mem_we, mem_re  output  1/1  memory strobes.
REQ-018 mem_addr, mem_wdata  output  AW/DW  memory address and write data.
REQ-019 mem_rdata  input  DW  memory read data, valid one cycle after mem_re.

Function
REQ-020 Grant decision SHALL be combinational within the request cycle: at most one of cpu_grant and host_gnt high per cycle.
REQ-021 cpu_req only -> CPU granted; host_req only -> host granted; neither -> mem_we = mem_re = 0.
REQ-022 Both requests, wait_cnt < STARVE_LIMIT -> CPU granted, wait_cnt increments.
REQ-023 Both requests, wait_cnt == STARVE_LIMIT -> host granted, cpu_stall = 1 that cycle, wait_cnt cleared next edge.
REQ-024 cpu_stall SHALL equal cpu_req AND NOT cpu_grant.
REQ-025 wait_cnt (4-bit) SHALL increment only on cycles with host_req and not host_gnt, saturate at STARVE_LIMIT, and clear on host_gnt or when host_req is low.
REQ-026 Mux: mem_addr/mem_wdata from the granted requester; mem_we = grant AND we; mem_re = grant AND NOT we; with no grant, mem_addr/mem_wdata SHALL be 0.
REQ-027 Read-owner FSM, states IDLE, CPU_RD, HOST_RD; next state = CPU_RD on a granted CPU read, HOST_RD on a granted host read, IDLE otherwise; updated every edge.
REQ-028 In HOST_RD: host_rvalid = 1 and host_rdata = mem_rdata; otherwise host_rvalid = 0 and host_rdata holds its last value.
REQ-029 In CPU_RD: cpu_rdata = mem_rdata; otherwise cpu_rdata holds its last value.
REQ-030 Read latency is 1 cycle from grant to data/rvalid; back-to-back reads are allowed every cycle.
REQ-031 Writes complete in the grant cycle and do not produce rvalid.
REQ-032 A host write and a CPU read to the same address in consecutive cycles SHALL be serviced in grant order, with no reordering.

Reset
REQ-033 While reset = 0: FSM = IDLE, wait_cnt = 0, host_rvalid = 0, cpu_rdata = 0, host_rdata = 0.
REQ-034 While reset = 0: host_gnt = 0, mem_we = mem_re = 0, cpu_stall = 0, regardless of inputs.
REQ-035 A read in flight at reset assertion SHALL be discarded; no rvalid after reset release.
REQ-036 First grant SHALL be possible on the first rising edge after reset returns to 1.

Verification
REQ-037 Host-only read addr 0x10, memory holds 0x5A -> host_gnt in cycle 0; host_rvalid = 1 with host_rdata = 0x5A in cycle 1.
REQ-038 cpu_req and host_req held continuously, STARVE_LIMIT = 4 -> CPU granted cycles 0-3; host granted with cpu_stall = 1 in cycle 4; CPU granted in cycle 5.
REQ-039 Host write 0x33 to addr 0x08, then CPU read of addr 0x08 -> cpu_rdata = 0x33 one cycle after the CPU grant.
REQ-040 Host read granted, reset pulled low before the next edge, then released -> host_rvalid stays 0, wait_cnt = 0, all strobes 0.
REQ-041 host_req dropped after 2 losing cycles and reasserted -> wait_cnt restarts at 0, so forced grant occurs only after 4 further losing cycles.
REQ-042 Alternating CPU read and host read every cycle, no contention -> each requester's rdata is correct and rvalid is never attributed to the wrong requester.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and a host loader/dump port.
// The CPU wins contention until the host has lost STARVE_LIMIT cycles in a row.
module dmem_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_rd_state,
    output logic [3:0]    dbg_wait_cnt
);

    // Handshake: a request is held by its owner; grant is combinational in the
    // request cycle, writes retire at that edge, read data returns on the next cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        HOST_RD = 2'd2
    } rd_state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    rd_state_e     rd_state_q, rd_state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] host_rdata_q;
    logic          cpu_grant;
    logic          host_forced;

    // Reset gates every grant so no strobe can escape while reset is low.
    assign host_forced = (wait_cnt_q == LIMIT);
    assign host_gnt    = reset & host_req & (~cpu_req | host_forced);
    assign cpu_grant   = reset & cpu_req & ~host_gnt;
    assign cpu_stall   = reset & cpu_req & ~cpu_grant;

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (host_gnt) begin
            mem_we    = host_we;
            mem_re    = ~host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (cpu_grant) begin
            mem_we    = cpu_we;
            mem_re    = ~cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (host_req && !host_gnt) begin
            wait_cnt_d = (wait_cnt_q == LIMIT) ? LIMIT : wait_cnt_q + 4'd1;
        end
    end

    always_comb begin
        rd_state_d = IDLE;
        if (cpu_grant && !cpu_we) begin
            rd_state_d = CPU_RD;
        end else if (host_gnt && !host_we) begin
            rd_state_d = HOST_RD;
        end
    end

    // The read owner is recorded at the grant edge so returning data is steered
    // to whoever issued it, even when the other side is granted in that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_state_q   <= IDLE;
            wait_cnt_q   <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            wait_cnt_q <= wait_cnt_d;
            if (rd_state_q == CPU_RD) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (rd_state_q == HOST_RD) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_rdata    = (rd_state_q == CPU_RD) ? mem_rdata : cpu_rdata_q;
    assign host_rdata   = (rd_state_q == HOST_RD) ? mem_rdata : host_rdata_q;
    assign host_rvalid  = (rd_state_q == HOST_RD);
    assign dbg_rd_state = rd_state_q;
    assign dbg_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural memory plus a reference
// model of grant order, host starvation and per-requester read return.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic          cpu_req, cpu_we, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_rd_state;
  logic [3:0]    dbg_wait_cnt;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_rd_state(dbg_rd_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // behavioural synchronous memory: data one cycle after mem_re
  logic [DW-1:0] sim_mem [256];
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_we) sim_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= sim_mem[mem_addr];
  end

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] shadow [256];
  int m_wait;                 // consecutive cycles the host has lost
  logic [DW-1:0] exp_q[$];    // read data due next cycle
  bit owner_q[$];             // 1 = host owns that read
  logic [DW-1:0] exp_cpu_rd, exp_host_rd;

  task automatic model_reset();
    m_wait = 0;
    exp_q.delete();
    owner_q.delete();
    exp_cpu_rd = '0;
    exp_host_rd = '0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic do_cycle(input bit creq, input bit cwe, input logic [AW-1:0] caddr,
                          input logic [DW-1:0] cwd, input bit hreq, input bit hwe,
                          input logic [AW-1:0] haddr, input logic [DW-1:0] hwd,
                          output bit gnt_seen, output bit stall_seen);
    bit host_wins, cpu_wins, exp_rv;
    logic e_we, e_re;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
    exp_rv = 1'b0;
    if (exp_q.size() > 0) begin
      if (owner_q[0]) begin
        exp_host_rd = exp_q[0];
        exp_rv = 1'b1;
      end else begin
        exp_cpu_rd = exp_q[0];
      end
      void'(exp_q.pop_front());
      void'(owner_q.pop_front());
    end
    host_wins = hreq && (!creq || m_wait >= LIMIT);
    cpu_wins = creq && !host_wins;
    e_we = 1'b0; e_re = 1'b0; e_addr = '0; e_wd = '0;
    if (host_wins) begin
      e_we = hwe; e_re = !hwe; e_addr = haddr; e_wd = hwd;
    end else if (cpu_wins) begin
      e_we = cwe; e_re = !cwe; e_addr = caddr; e_wd = cwd;
    end
    #3;
    checks++; if (host_gnt !== host_wins) begin failures++; $display("FAIL host_gnt t=%0t got=%b exp=%b", $time, host_gnt, host_wins); end
    checks++; if (cpu_stall !== (creq && !cpu_wins)) begin failures++; $display("FAIL cpu_stall t=%0t got=%b exp=%b", $time, cpu_stall, creq && !cpu_wins); end
    checks++; if (mem_we !== e_we) begin failures++; $display("FAIL mem_we t=%0t got=%b exp=%b", $time, mem_we, e_we); end
    checks++; if (mem_re !== e_re) begin failures++; $display("FAIL mem_re t=%0t got=%b exp=%b", $time, mem_re, e_re); end
    checks++; if (mem_addr !== e_addr) begin failures++; $display("FAIL mem_addr t=%0t got=%h exp=%h", $time, mem_addr, e_addr); end
    checks++; if (mem_wdata !== e_wd) begin failures++; $display("FAIL mem_wdata t=%0t got=%h exp=%h", $time, mem_wdata, e_wd); end
    checks++; if (host_rvalid !== exp_rv) begin failures++; $display("FAIL host_rvalid t=%0t got=%b exp=%b", $time, host_rvalid, exp_rv); end
    checks++; if (host_rdata !== exp_host_rd) begin failures++; $display("FAIL host_rdata t=%0t got=%h exp=%h", $time, host_rdata, exp_host_rd); end
    checks++; if (cpu_rdata !== exp_cpu_rd) begin failures++; $display("FAIL cpu_rdata t=%0t got=%h exp=%h", $time, cpu_rdata, exp_cpu_rd); end
    gnt_seen = host_gnt;
    stall_seen = cpu_stall;
    if (host_wins || !hreq) m_wait = 0;
    else if (m_wait < LIMIT) m_wait++;
    if (host_wins && !hwe) begin exp_q.push_back(shadow[haddr]); owner_q.push_back(1'b1); end
    if (cpu_wins && !cwe) begin exp_q.push_back(shadow[caddr]); owner_q.push_back(1'b0); end
    if (host_wins && hwe) shadow[haddr] = hwd;
    if (cpu_wins && cwe) shadow[caddr] = cwd;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    bit g, s;
    do_cycle(0, 0, '0, '0, 0, 0, '0, '0, g, s);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
      host_req = 1'b1; host_we = 1'($urandom_range(0, 1)); host_addr = AW'($urandom); host_wdata = DW'($urandom);
      #3;
      checks++; if (host_gnt !== 1'b0) begin failures++; $display("FAIL rst_host_gnt got=%b exp=0", host_gnt); end
      checks++; if ({mem_we, mem_re} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%b exp=00", {mem_we, mem_re}); end
      checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_cpu_stall got=%b exp=0", cpu_stall); end
      checks++; if (host_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", host_rvalid); end
      checks++; if ({cpu_rdata, host_rdata} !== '0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0", cpu_rdata, host_rdata); end
      checks++; if (dbg_wait_cnt !== 4'd0) begin failures++; $display("FAIL rst_wait_cnt got=%0d exp=0", dbg_wait_cnt); end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_fill();
    bit g, s;
    for (int a = 0; a < 256; a++) do_cycle(0, 0, '0, '0, 1, 1, AW'(a), DW'($urandom), g, s);
    idle_cycle();
  endtask

  task automatic test_host_read();
    bit g, s;
    idle_cycle();
    do_cycle(0, 0, '0, '0, 1, 1, 8'h10, 8'h5A, g, s);
    do_cycle(0, 0, '0, '0, 1, 0, 8'h10, '0, g, s);
    checks++; if (g !== 1'b1) begin failures++; $display("FAIL host_read_gnt got=%b exp=1", g); end
    #3;
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== 8'h5A) begin failures++; $display("FAIL host_read_data rvalid=%b data=%h exp=1/5a", host_rvalid, host_rdata); end
    #7;
    idle_cycle();
  endtask

  task automatic test_starvation();
    bit g, s;
    idle_cycle();
    for (int i = 0; i < 7; i++) begin
      do_cycle(1, 0, AW'($urandom), '0, 1, 0, AW'($urandom), '0, g, s);
      checks++; if (g !== (i == 4) || s !== (i == 4)) begin failures++; $display("FAIL starve_cycle%0d gnt=%b stall=%b exp=%b", i, g, s, i == 4); end
    end
    idle_cycle();
  endtask

  task automatic test_write_then_read();
    bit g, s;
    idle_cycle();
    do_cycle(0, 0, '0, '0, 1, 1, 8'h08, 8'h33, g, s);
    do_cycle(1, 0, 8'h08, '0, 0, 0, '0, '0, g, s);
    idle_cycle();
    checks++; if (cpu_rdata !== 8'h33) begin failures++; $display("FAIL wr_rd_order got=%h exp=33", cpu_rdata); end
  endtask

  task automatic test_inflight_reset();
    bit g, s;
    idle_cycle();
    do_cycle(1, 1, AW'($urandom), DW'($urandom), 1, 0, 8'h20, '0, g, s);
    do_cycle(1, 1, AW'($urandom), DW'($urandom), 1, 0, 8'h20, '0, g, s);
    cpu_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 8'h21;
    #2;
    checks++; if (host_gnt !== 1'b1) begin failures++; $display("FAIL inflight_gnt got=%b exp=1", host_gnt); end
    reset = 1'b0;
    #1;
    checks++; if ({host_gnt, mem_re} !== 2'b00) begin failures++; $display("FAIL inflight_gate got=%b exp=00", {host_gnt, mem_re}); end
    @(posedge clk); #1;
    host_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    #3;
    checks++; if (dbg_wait_cnt !== 4'd0) begin failures++; $display("FAIL inflight_wait_cnt got=%0d exp=0", dbg_wait_cnt); end
    checks++; if ({host_rvalid, mem_we, mem_re} !== 3'b000) begin failures++; $display("FAIL inflight_quiet got=%b exp=000", {host_rvalid, mem_we, mem_re}); end
    @(posedge clk); #1;
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_drop_rearm();
    bit g, s;
    bit hr;
    idle_cycle();
    for (int i = 0; i < 9; i++) begin
      hr = (i != 2);
      do_cycle(1, 0, AW'($urandom), '0, hr, 0, AW'($urandom), '0, g, s);
      checks++; if (g !== (i == 7)) begin failures++; $display("FAIL rearm_cycle%0d gnt=%b exp=%b", i, g, i == 7); end
    end
    idle_cycle();
  endtask

  task automatic test_alternate();
    bit g, s;
    idle_cycle();
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) do_cycle(1, 0, AW'($urandom), '0, 0, 0, '0, '0, g, s);
      else do_cycle(0, 0, '0, '0, 1, 0, AW'($urandom), '0, g, s);
    end
    idle_cycle();
  endtask

  task automatic test_random();
    bit g, s;
    for (int i = 0; i < 400; i++) begin
      do_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
               $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), g, s);
    end
    idle_cycle();
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_host_read();
    test_starvation();
    test_write_then_read();
    test_inflight_reset();
    test_drop_rearm();
    test_alternate();
    test_random();
    test_reset();
    idle_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end
endmodule
